// File: rtl/crop_video_axis_snk_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crop_video_axis_snk_chk_pkg
// Purpose  : Shared types and constants for the crop_video AXIS sink checker
// Revision : 1.0 - initial release
// ============================================================================
package crop_video_axis_snk_chk_pkg;

    // Frame-checker FSM states
    typedef enum logic [0:0] {
        ST_WAIT_SOF = 1'b0,
        ST_IN_FRAME = 1'b1
    } chk_state_t;

    // Backpressure generator modes (3 is reserved and behaves like 0)
    typedef enum logic [1:0] {
        BP_ALWAYS   = 2'd0,
        BP_LFSR     = 2'd1,
        BP_PERIODIC = 2'd2,
        BP_RESERVED = 2'd3
    } bp_mode_t;

    // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR map to bits 0,2,3,5
    localparam logic [15:0] c_LFSR_TAP_MASK     = 16'h002D;
    localparam logic [15:0] c_LFSR_SEED_DEFAULT = 16'hACE1;

endpackage
`default_nettype wire

// File: rtl/crop_video_axis_snk_bp_gen.sv
`default_nettype none
// ============================================================================
// Module   : crop_video_axis_snk_bp_gen
// Purpose  : tready generator: always-ready, LFSR pseudo-random or periodic
// Revision : 1.0 - initial release
// ============================================================================
module crop_video_axis_snk_bp_gen
    import crop_video_axis_snk_chk_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_enable,
    input  logic [1:0]  i_mode,
    input  logic [15:0] i_seed,
    output logic        o_tready
);

    logic [15:0] r_lfsr;
    logic [1:0]  r_cnt;
    logic        r_tready;
    logic        w_fb;
    logic [15:0] w_seed;

    // A zero seed would lock the LFSR, so substitute the default
    assign w_seed = (i_seed == 16'h0000) ? c_LFSR_SEED_DEFAULT : i_seed;
    assign w_fb   = ^(r_lfsr & c_LFSR_TAP_MASK);

    // LFSR, free-running phase counter and registered tready mux
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lfsr   <= c_LFSR_SEED_DEFAULT;
            r_cnt    <= 2'd0;
            r_tready <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 2'd1;
            if (!i_enable) begin
                r_lfsr   <= w_seed;
                r_tready <= 1'b0;
            end else begin
                r_lfsr <= {w_fb, r_lfsr[15:1]};
                case (i_mode)
                    BP_LFSR:     r_tready <= r_lfsr[0];
                    BP_PERIODIC: r_tready <= (r_cnt != 2'd3);
                    default:     r_tready <= 1'b1;
                endcase
            end
        end
    end

    assign o_tready = r_tready;

endmodule
`default_nettype wire

// File: rtl/crop_video_axis_snk_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : crop_video_axis_snk_frame_checker
// Purpose  : AXIS video sink with backpressure, frame geometry checking,
//            frame counting and per-frame checksum
// Revision : 1.0 - initial release
// ============================================================================
module crop_video_axis_snk_frame_checker
    import crop_video_axis_snk_chk_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_COMP   = 3,
    parameter int PPC        = 1,
    parameter int DIM_WIDTH  = 13
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [PPC*NUM_COMP*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                               s_axis_tvalid,
    output logic                               s_axis_tready,
    input  logic                               s_axis_tuser,
    input  logic                               s_axis_tlast,
    input  logic                               cfg_enable,
    input  logic [DIM_WIDTH-1:0]               cfg_width,
    input  logic [DIM_WIDTH-1:0]               cfg_height,
    input  logic [1:0]                         bp_mode,
    input  logic [15:0]                        bp_seed,
    input  logic                               err_clear,
    output logic                               frame_done,
    output logic [15:0]                        frame_count,
    output logic [31:0]                        frame_checksum,
    output logic                               err_missing_sof,
    output logic                               err_extra_sof,
    output logic                               err_early_eol,
    output logic                               err_late_eol
);

    localparam int                   c_PPC_SHIFT = $clog2(PPC);
    localparam int                   c_NCOMP     = PPC * NUM_COMP;
    localparam logic [DIM_WIDTH-1:0] c_ONE       = {{(DIM_WIDTH-1){1'b0}}, 1'b1};

    chk_state_t           r_state;
    logic [DIM_WIDTH-1:0] r_x, r_y, r_width, r_height;
    logic [31:0]          r_cks, r_checksum;
    logic [15:0]          r_count;
    logic                 r_done;
    logic                 r_e_miss, r_e_extra, r_e_early, r_e_late;

    logic                 w_acc, w_take, w_x_last, w_frame_end;
    logic [DIM_WIDTH-1:0] w_width_eff, w_height_eff, w_beats_m1, w_h_m1;
    logic [DIM_WIDTH-1:0] w_x_cur, w_y_cur;
    logic [31:0]          w_beat_sum, w_cks_cur;
    logic                 w_n_miss, w_n_extra, w_n_early, w_n_late;

    crop_video_axis_snk_bp_gen u_bp_gen (
        .clock    (clock),
        .reset    (reset),
        .i_enable (cfg_enable),
        .i_mode   (bp_mode),
        .i_seed   (bp_seed),
        .o_tready (s_axis_tready)
    );

    // Sum of every component in the current beat, widened to 32 bits
    always_comb begin
        w_beat_sum = 32'd0;
        for (int i = 0; i < c_NCOMP; i++) begin
            w_beat_sum = w_beat_sum + 32'(s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // An SOF beat restarts position and checksum and uses the live geometry
    assign w_acc        = s_axis_tvalid & s_axis_tready & cfg_enable;
    assign w_take       = w_acc & (s_axis_tuser | (r_state == ST_IN_FRAME));
    assign w_width_eff  = s_axis_tuser ? cfg_width  : r_width;
    assign w_height_eff = s_axis_tuser ? cfg_height : r_height;
    assign w_beats_m1   = (w_width_eff >> c_PPC_SHIFT) - c_ONE;
    assign w_h_m1       = w_height_eff - c_ONE;
    assign w_x_cur      = s_axis_tuser ? '0 : r_x;
    assign w_y_cur      = s_axis_tuser ? '0 : r_y;
    assign w_cks_cur    = (s_axis_tuser ? 32'd0 : r_cks) + w_beat_sum;
    assign w_x_last     = (w_x_cur >= w_beats_m1);
    assign w_frame_end  = w_take & s_axis_tlast & (w_y_cur == w_h_m1);

    assign w_n_miss  = w_acc & ~s_axis_tuser & (r_state == ST_WAIT_SOF);
    assign w_n_extra = w_take & s_axis_tuser & (r_state == ST_IN_FRAME);
    assign w_n_early = w_take & s_axis_tlast & ~w_x_last;
    assign w_n_late  = w_take & ~s_axis_tlast & w_x_last;

    // Frame FSM, position counters, checksum and frame statistics
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_WAIT_SOF;
            r_x        <= '0;
            r_y        <= '0;
            r_width    <= '0;
            r_height   <= '0;
            r_cks      <= 32'd0;
            r_checksum <= 32'd0;
            r_count    <= 16'd0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!cfg_enable) begin
                r_state <= ST_WAIT_SOF;
                r_x     <= '0;
                r_y     <= '0;
                r_cks   <= 32'd0;
            end else if (w_take) begin
                if (s_axis_tuser) begin
                    r_width  <= cfg_width;
                    r_height <= cfg_height;
                end
                if (s_axis_tlast) begin
                    r_x <= '0;
                    if (w_frame_end) begin
                        r_state    <= ST_WAIT_SOF;
                        r_y        <= '0;
                        r_cks      <= 32'd0;
                        r_done     <= 1'b1;
                        r_count    <= r_count + 16'd1;
                        r_checksum <= w_cks_cur;
                    end else begin
                        r_state <= ST_IN_FRAME;
                        r_y     <= w_y_cur + c_ONE;
                        r_cks   <= w_cks_cur;
                    end
                end else begin
                    // Past the last beat the position saturates until tlast
                    r_state <= ST_IN_FRAME;
                    r_x     <= w_x_last ? w_x_cur : w_x_cur + c_ONE;
                    r_y     <= w_y_cur;
                    r_cks   <= w_cks_cur;
                end
            end
        end
    end

    // Sticky error flags; a new error wins over a simultaneous clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_e_miss  <= 1'b0;
            r_e_extra <= 1'b0;
            r_e_early <= 1'b0;
            r_e_late  <= 1'b0;
        end else begin
            r_e_miss  <= (r_e_miss  & ~err_clear) | w_n_miss;
            r_e_extra <= (r_e_extra & ~err_clear) | w_n_extra;
            r_e_early <= (r_e_early & ~err_clear) | w_n_early;
            r_e_late  <= (r_e_late  & ~err_clear) | w_n_late;
        end
    end

    assign frame_done      = r_done;
    assign frame_count     = r_count;
    assign frame_checksum  = r_checksum;
    assign err_missing_sof = r_e_miss;
    assign err_extra_sof   = r_e_extra;
    assign err_early_eol   = r_e_early;
    assign err_late_eol    = r_e_late;

endmodule
`default_nettype wire

// File: doc/crop_video_axis_snk_frame_checker.md
# crop_video_axis_snk_frame_checker

Synthesizable, parametrised AXI4-Stream video sink for the crop_video output path. It terminates the cropped stream and generates `tready` backpressure: always-ready, pseudo-random or periodic. It checks frame geometry (SOF/EOL placement against programmed width and height) and reports per-frame count, checksum and sticky error flags. It is the next-generation successor to the single-pixel sink interface: multi-pixel-per-clock, multi-component, with in-hardware protocol checking.

## Interface
Parameters:
- `DATA_WIDTH`, 8: bits per colour component
- `NUM_COMP`, 3: components per pixel
- `PPC`, 1: pixels per beat (1, 2 or 4)
- `DIM_WIDTH`, 13: width of `cfg_width`, `cfg_height` and the internal counters

Ports (name, direction, width, meaning):
- `clock` in 1: the only clock
- `reset` in 1: asynchronous, active-low reset
- `s_axis_tdata` in PPC*NUM_COMP*DATA_WIDTH: pixel data
- `s_axis_tvalid` in 1: beat valid
- `s_axis_tready` out 1: beat ready (registered)
- `s_axis_tuser` in 1: start of frame (SOF), on first beat of frame
- `s_axis_tlast` in 1: end of line (EOL)
- `cfg_enable` in 1: 0 = checker idle, tready low, LFSR reloads
- `cfg_width` in DIM_WIDTH: pixels per line, multiple of PPC, ≥PPC
- `cfg_height` in DIM_WIDTH: lines per frame, ≥1
- `bp_mode` in 2: 0 always ready, 1 LFSR, 2 periodic (low 1 cycle in 4), 3 reserved (acts as 0)
- `bp_seed` in 16: LFSR seed
- `err_clear` in 1: clears sticky error flags
- `frame_done` out 1: one-cycle pulse per correctly terminated frame
- `frame_count` out 16: completed frames, wraps at 2^16
- `frame_checksum` out 32: sum of all components of last completed frame, mod 2^32
- `err_missing_sof` out 1: sticky
- `err_extra_sof` out 1: sticky
- `err_early_eol` out 1: sticky
- `err_late_eol` out 1: sticky

## Operation
- Accepted beat = `tvalid & tready`; all checking uses accepted beats only.
- `BEATS` = cfg_width/PPC. cfg_width and cfg_height are latched at each accepted SOF beat.
- FSM states:
  - WAIT_SOF:
    - Accepted beat with tuser=0: discarded, set err_missing_sof.
    - Accepted beat with tuser=1: x=0, y=0, checksum=beat sum; go IN_FRAME. If the same beat has tlast, the line-end rules below also apply to it.
  - IN_FRAME, per accepted beat:
    - tuser=1: set err_extra_sof and restart the frame exactly as in WAIT_SOF. frame_count is not incremented.
    - tlast=1 with x<BEATS-1: set err_early_eol, then line end.
    - tlast=1 with x=BEATS-1: line end.
    - tlast=0 with x=BEATS-1: set err_late_eol. x saturates; the line still ends only on tlast.
    - Line end: x=0, y+1. If y=latched height-1, the frame completes: frame_done pulse, frame_count+1, frame_checksum updated; go WAIT_SOF.
- cfg_enable=0: FSM forced to WAIT_SOF, counters cleared. frame_count, checksum and error flags are held.
- Sticky errors: err_clear clears them. If err_clear and a new error occur in the same cycle, the error stays set.
- Backpressure generator:
  - Mode 1: 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle; tready=lfsr[0]. A seed of 0 is replaced by 16'hACE1.
  - Mode 2: 2-bit free-running counter; tready low when count=3.

## Timing
- Reset values: all outputs 0, FSM WAIT_SOF, LFSR = 16'hACE1.
- tready is a register. It goes high (mode 0) one cycle after cfg_enable rises. It goes low one cycle after cfg_enable falls.
- frame_done, frame_count and frame_checksum update one cycle after the final accepted beat. This gives zero bubble between frames.
- Error flags assert one cycle after the offending beat.
- Checksum: per-beat sum of PPC*NUM_COMP components, widened to 32 bits, accumulated combinationally into a register each accepted beat.
- Reset mid-frame: everything returns to reset values immediately; no frame_done is produced.
- Sustained throughput: one beat per cycle in mode 0.

## Structure
- Package `crop_video_axis_snk_chk_pkg` holds:
  - FSM state enum
  - bp_mode enum
  - LFSR tap mask and default seed constant
- Sub-module `crop_video_axis_snk_bp_gen` holds the LFSR, the periodic counter and the registered tready mux. The parent contains the FSM, the counters, the checksum and the flags.

## Test plan
- PPC=1, 4x2 frame, mode 0, data all 1 (NUM_COMP=3) -> frame_done once, frame_count=1, frame_checksum=24, no errors.
- PPC=2, 8x3 frame, mode 1, seed 16'h1 -> tready toggles pseudo-randomly; the 12 beats are all accepted; frame_count=1; no errors.
- Line with tlast at beat 2 of 4 -> err_early_eol=1; frame still completes after cfg_height lines.
- Line of 4 beats with no tlast until beat 6 -> err_late_eol=1 at beat 4; line ends at beat 6.
- Beat without SOF after reset, then SOF mid-frame -> err_missing_sof=1, err_extra_sof=1; frame_count increments only for the restarted frame.
- Assert reset during line 1 of 2, then release -> all outputs 0; the next clean frame gives frame_count=1.
